f2i_seq: RTL and testbench
==========================

Name: f2i_seq

Overview:
- Multi-cycle float-to-integer converter: the inverse of the ALU's integer-to-float path.
- Converts a 16-bit float (sign[15], exp[14:7] bias 127, mant[6:0], hidden 1) to a 16-bit two's-complement integer.
- Truncates toward zero and saturates on overflow.
- Sits beside the ALU as the backing unit for `OPf2i`, using valid/ready handshakes on both sides.

Parameters:
- EXP_BIAS, 127, exponent bias.
- NAN_RESULT, 16'h0000, integer produced for NaN inputs.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  in_float is valid
- in_ready  out  1  block can accept an operand
- in_float  in  16  float operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_int  out  16  two's-complement result
- out_ovf  out  1  result saturated, or input was NaN or inf
- out_inexact  out  1  nonzero fractional bits were discarded

Behaviour:
- Reset (rst_n low at an edge): state IDLE; in_ready=1; out_valid=0; out_int=0; out_ovf=0; out_inexact=0; shift register and counter cleared. Reset in any state aborts the conversion and discards the operand.
- States: IDLE, SHIFT, NEG, DONE.
- in_ready=1 only in IDLE. in_valid while busy is ignored; there is no queue.
- Accept edge (IDLE, in_valid=1), classify with e=exp:
  - e==255, mant!=0 (NaN): result NAN_RESULT, ovf=1, go to DONE.
  - e==255, mant==0 (inf), or e>=EXP_BIAS+15: saturate to 16'h7FFF (+) or 16'h8000 (-), ovf=1. Exception: sign=1, e=142, mant=0 is exactly -32768, so ovf=0. Go to DONE.
  - e<EXP_BIAS (includes zero and denormal): result 0, ovf=0, inexact=(in_float[14:0]!=0). Go to DONE.
  - Otherwise: mag={8'b0,1'b1,mant}; cnt=e-(EXP_BIAS+7), a signed 5-bit value in -7..+7; sticky=0. Go to SHIFT if cnt!=0, else NEG.
- SHIFT, one bit per cycle:
  - cnt>0: mag<<=1, cnt-=1.
  - cnt<0: sticky|=mag[0], mag>>=1, cnt+=1.
  - Exit to NEG at the edge where cnt reaches 0.
- NEG: out_int = sign ? (~mag+1) : mag; ovf=0; inexact=sticky; go to DONE. Maximum magnitude is 0x7F80, so no overflow is possible here.
- DONE: out_valid=1. out_int, out_ovf and out_inexact are stable until out_ready=1 at an edge, then return to IDLE with out_valid=0.
- Latency from accept edge to out_valid high:
  - 1 cycle for special cases.
  - 2+|cnt| cycles for normal cases, maximum 9.
  - Throughput: one conversion per latency+1 cycles with out_ready held high.
- out_ready=1 outside DONE has no effect.
- Result fields are updated only on entry to DONE; they hold their values in IDLE.

Decomposition:
- Shared package/header:
  - float field macros: `FSign [15], `FExp [14:7], `FMant [6:0]
  - bias constant, 127
  - saturation constants, 16'h7FFF and 16'h8000
  - `OPf2i opcode, reused from the ALU defines
  - state encodings
- Sub-module f2i_classify (combinational):
  - inputs: in_float
  - outputs: class (nan/sat/small/normal), special result value, ovf, inexact, initial cnt
- The top level holds the FSM, shift register, counter and output registers.

Test Plan:
- 16'h3F80 (1.0) -> out_int=16'h0001, ovf=0, inexact=0, out_valid 9 cycles after accept.
- 16'hC2F6 (-123.0) -> out_int=16'hFF85, ovf=0, inexact=0, latency 3. 16'h46FF -> 16'h7F80, latency 9.
- 16'h4700 -> 16'h7FFF with ovf=1. 16'hC700 -> 16'h8000 with ovf=0. 16'hFF80 (-inf) -> 16'h8000 with ovf=1. Each has latency 1.
- 16'h7FC0 (NaN) -> 16'h0000, ovf=1. 16'h3F00 (0.5) -> 0, inexact=1. 16'h0000 -> 0, inexact=0. 16'h3FC0 (1.5) -> 1, inexact=1.
- Backpressure: convert 16'h4000 (2.0) with out_ready low for 5 cycles -> out_valid and out_int=2 held stable; in_valid pulses during busy are ignored (in_ready=0); one-cycle out_ready -> IDLE.
- Reset: pull rst_n low for one edge during SHIFT of 16'h3F80 -> next cycle out_valid=0, in_ready=1, out_int=0. A following conversion of 16'h4040 (3.0) returns 16'h0003.

Source files
------------

// File: rtl/f2i_seq_pkg.sv
// Shared definitions for the float-to-integer converter: float field
// selectors, bias and saturation constants, opcode and state encodings.
`ifndef F2I_SEQ_DEFS
`define F2I_SEQ_DEFS
`define FSign 15
`define FExp  14:7
`define FMant 6:0
`define OPf2i 5'h13
`endif

package f2i_seq_pkg;

  localparam int          F2I_EXP_BIAS = 127;
  localparam logic [15:0] F2I_SAT_POS  = 16'h7FFF;
  localparam logic [15:0] F2I_SAT_NEG  = 16'h8000;

  // Operand class decided on the accept edge
  typedef enum logic [1:0] {
    CLS_NAN,
    CLS_SAT,
    CLS_SMALL,
    CLS_NORMAL
  } f2i_cls_e;

  // Converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_NEG,
    ST_DONE
  } f2i_state_e;

  // Saturation value for a given sign
  function automatic logic [15:0] sat_value(input logic sign);
    return sign ? F2I_SAT_NEG : F2I_SAT_POS;
  endfunction

endpackage

// File: rtl/f2i_seq_classify.sv
// Combinational operand classifier: separates NaN, saturating, sub-unity
// and normal operands, and produces the result for the special cases plus
// the initial signed shift count for normal ones.
module f2i_classify
  import f2i_seq_pkg::*;
#(
  parameter int          EXP_BIAS   = F2I_EXP_BIAS,
  parameter logic [15:0] NAN_RESULT = 16'h0000
) (
  input  logic [15:0]       float_i,
  output f2i_cls_e          cls_o,
  output logic [15:0]       spec_val_o,
  output logic              spec_ovf_o,
  output logic              spec_inexact_o,
  output logic signed [4:0] cnt_o
);

  logic       sign_s;
  logic [7:0] exp_s;
  logic [6:0] mant_s;

  assign sign_s = float_i[`FSign];
  assign exp_s  = float_i[`FExp];
  assign mant_s = float_i[`FMant];

  // Classify the operand; normal operands have exponent in bias..bias+14
  always_comb begin
    cls_o          = CLS_NORMAL;
    spec_val_o     = 16'h0000;
    spec_ovf_o     = 1'b0;
    spec_inexact_o = 1'b0;
    cnt_o          = 5'(exp_s - 8'(EXP_BIAS + 7));
    if (exp_s == 8'hFF) begin
      if (mant_s != 7'd0) begin
        cls_o      = CLS_NAN;
        spec_val_o = NAN_RESULT;
        spec_ovf_o = 1'b1;
      end else begin
        cls_o      = CLS_SAT;
        spec_val_o = sat_value(sign_s);
        spec_ovf_o = 1'b1;
      end
    end else if (exp_s >= 8'(EXP_BIAS + 15)) begin
      cls_o      = CLS_SAT;
      spec_val_o = sat_value(sign_s);
      // -2^15 is representable exactly, so it is not an overflow
      if (sign_s && (exp_s == 8'(EXP_BIAS + 15)) && (mant_s == 7'd0)) begin
        spec_ovf_o = 1'b0;
      end else begin
        spec_ovf_o = 1'b1;
      end
    end else if (exp_s < 8'(EXP_BIAS)) begin
      cls_o          = CLS_SMALL;
      spec_inexact_o = (float_i[14:0] != 15'd0);
    end else begin
      cls_o = CLS_NORMAL;
    end
  end

endmodule

// File: rtl/f2i_seq.sv
// Multi-cycle float16 (1/8/7) to int16 converter with truncation toward
// zero and saturation. Special operands finish in one cycle; normal ones
// shift the significand one bit per cycle, then negate if required.
module f2i_seq
  import f2i_seq_pkg::*;
#(
  parameter int          EXP_BIAS   = F2I_EXP_BIAS,
  parameter logic [15:0] NAN_RESULT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_float,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_int,
  output logic        out_ovf,
  output logic        out_inexact
);

  f2i_state_e        state_q, state_d;
  logic [15:0]       mag_q, mag_d;
  logic signed [4:0] cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              sign_q, sign_d;
  logic [15:0]       int_q, int_d;
  logic              ovf_q, ovf_d;
  logic              inexact_q, inexact_d;

  f2i_cls_e          cls_s;
  logic [15:0]       spec_val_s;
  logic              spec_ovf_s;
  logic              spec_inexact_s;
  logic signed [4:0] cnt_init_s;

  f2i_classify #(
    .EXP_BIAS   (EXP_BIAS),
    .NAN_RESULT (NAN_RESULT)
  ) u_classify (
    .float_i        (in_float),
    .cls_o          (cls_s),
    .spec_val_o     (spec_val_s),
    .spec_ovf_o     (spec_ovf_s),
    .spec_inexact_o (spec_inexact_s),
    .cnt_o          (cnt_init_s)
  );

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign out_int     = int_q;
  assign out_ovf     = ovf_q;
  assign out_inexact = inexact_q;

  // Next-state logic: accept, shift toward alignment, negate, hold result
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    sign_d    = sign_q;
    int_d     = int_q;
    ovf_d     = ovf_q;
    inexact_d = inexact_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_float[`FSign];
          if (cls_s == CLS_NORMAL) begin
            mag_d    = {8'b0, 1'b1, in_float[`FMant]};
            cnt_d    = cnt_init_s;
            sticky_d = 1'b0;
            if (cnt_init_s != 5'sd0) begin
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_NEG;
            end
          end else begin
            int_d     = spec_val_s;
            ovf_d     = spec_ovf_s;
            inexact_d = spec_inexact_s;
            state_d   = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q < 5'sd0) begin
          sticky_d = sticky_q | mag_q[0];
          mag_d    = mag_q >> 1;
          cnt_d    = cnt_q + 5'sd1;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 5'sd1;
        end
        if (cnt_d == 5'sd0) begin
          state_d = ST_NEG;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_NEG: begin
        int_d     = sign_q ? (~mag_q + 16'd1) : mag_q;
        ovf_d     = 1'b0;
        inexact_d = sticky_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mag_q     <= 16'h0000;
      cnt_q     <= 5'sd0;
      sticky_q  <= 1'b0;
      sign_q    <= 1'b0;
      int_q     <= 16'h0000;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      sign_q    <= sign_d;
      int_q     <= int_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
    end
  end

endmodule

// File: tb/tb_f2i_seq.sv
// Directed testbench for f2i_seq with hand-computed expected values.
module tb_f2i_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_float;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_int;
  logic        out_ovf;
  logic        out_inexact;

  int total;
  int bad;

  f2i_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_float    (in_float),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_int     (out_int),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Present an operand at a falling edge, let it be accepted, then wait
  // for out_valid; returns the measured latency in cycles.
  task automatic start_conv(input logic [15:0] f, output int lat);
    @(negedge clk);
    chk("ready_before", in_ready, 1);
    in_valid = 1'b1;
    in_float = f;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] f, input logic [15:0] e_int,
                     input logic e_ovf, input logic e_inx, input int e_lat);
    int lat;
    start_conv(f, lat);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_int"}, out_int, e_int);
    chk({tag, "_ovf"}, out_ovf, e_ovf);
    chk({tag, "_inx"}, out_inexact, e_inx);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, out_valid, 0);
    chk({tag, "_idle_hold"}, out_int, e_int);
  endtask

  initial begin
    int lat;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_float  = 16'h0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_int", out_int, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_inx", out_inexact, 0);
    rst_n = 1'b1;

    run("one",      16'h3F80, 16'h0001, 1'b0, 1'b0, 9);
    run("m123",     16'hC2F6, 16'hFF85, 1'b0, 1'b0, 3);
    run("max",      16'h46FF, 16'h7F80, 1'b0, 1'b0, 9);
    run("sat_pos",  16'h4700, 16'h7FFF, 1'b1, 1'b0, 1);
    run("exact_mn", 16'hC700, 16'h8000, 1'b0, 1'b0, 1);
    run("ninf",     16'hFF80, 16'h8000, 1'b1, 1'b0, 1);
    run("nan",      16'h7FC0, 16'h0000, 1'b1, 1'b0, 1);
    run("half",     16'h3F00, 16'h0000, 1'b0, 1'b1, 1);
    run("zero",     16'h0000, 16'h0000, 1'b0, 1'b0, 1);
    run("onehalf",  16'h3FC0, 16'h0001, 1'b0, 1'b1, 9);
    run("neg1p5",   16'hBFC0, 16'hFFFF, 1'b0, 1'b1, 9);

    // Backpressure: result holds while out_ready is low, busy input ignored
    start_conv(16'h4000, lat);
    chk("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_float = 16'h4700;
      chk("bp_busy_ready", in_ready, 0);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_int", out_int, 16'h0002);
      chk("bp_ovf", out_ovf, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_int", out_int, 16'h0002);

    // Reset during SHIFT aborts the conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_float = 16'h3F80;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_busy", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs_valid", out_valid, 0);
    chk("rs_ready", in_ready, 1);
    chk("rs_int", out_int, 0);
    repeat (12) @(negedge clk);
    chk("rs_no_result", out_valid, 0);
    run("three", 16'h4040, 16'h0003, 1'b0, 1'b0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
